// File: rtl/index_mask_builder.sv
// -----------------------------------------------------------------------------
// index_mask_builder
//
// Collects a frame of faulty-lane indices (one 2-bit index per beat) and
// turns it into a 4-lane mask. The frame ends on the beat flagged with
// in_last. The finished result is then held on the output until downstream
// takes it. Only one frame is in flight at a time. While a result is held,
// the input side stalls.
//
// Ports
//   clk        in   1  rising-edge clock for all state
//   reset      in   1  asynchronous, active-high reset
//   in_valid   in   1  index beat valid
//   in_ready   out  1  block accepts an index beat this cycle (ACCUM state)
//   in_idx     in   2  faulty-lane index, 0..3
//   in_last    in   1  final beat of the frame
//   out_valid  out  1  frame result valid (HOLD state)
//   out_ready  in   1  downstream accepts the frame result
//   out_mask   out  4  bit i set iff index i appeared in the frame
//   out_top    out  2  position of the highest set bit of out_mask (0 if none)
//   out_count  out  3  beats accepted in the frame, saturating at 7
//   out_dup    out  1  some index appeared more than once in the frame
// -----------------------------------------------------------------------------
module index_mask_builder (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_idx,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_mask,
    output logic [1:0] out_top,
    output logic [2:0] out_count,
    output logic       out_dup
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t     state;
    state_t     next_state;

    logic [3:0] acc_mask;
    logic [2:0] acc_count;
    logic       acc_dup;

    logic       accept;
    logic       release_frame;
    logic [3:0] beat_onehot;
    logic [3:0] mask_next;
    logic [2:0] count_next;
    logic       dup_next;
    logic [1:0] top_next;

    // Handshake decoding. The ready/valid outputs come straight from the
    // state. out_ready therefore has no effect in ACCUM. in_valid has no
    // effect in HOLD.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = ACCUM;
                end
            end
            default: begin
                next_state = ACCUM;
            end
        endcase
    end

    assign accept        = in_valid  & in_ready;
    assign release_frame = out_valid & out_ready;

    // Accumulator values including the current beat. The last beat's
    // contribution must appear in the loaded result, so the output
    // registers take these next values rather than the stored ones.
    always_comb begin
        beat_onehot = 4'b0001 << in_idx;
        mask_next   = acc_mask | beat_onehot;
        count_next  = (acc_count == 3'd7) ? 3'd7 : acc_count + 3'd1;
        dup_next    = acc_dup | (|(acc_mask & beat_onehot));
    end

    // Leading-one position of the mask being loaded. An empty mask
    // reports 0. The loaded mask always holds at least the last beat's
    // bit, so that case cannot occur here.
    always_comb begin
        if (mask_next[3]) begin
            top_next = 2'd3;
        end else if (mask_next[2]) begin
            top_next = 2'd2;
        end else if (mask_next[1]) begin
            top_next = 2'd1;
        end else begin
            top_next = 2'd0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ACCUM;
        end else begin
            state <= next_state;
        end
    end

    // Frame accumulator. It is cleared when the held result is handed
    // off, so the first beat after a handshake starts a fresh frame. It
    // does not change while HOLD waits, because no beat is accepted then.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_mask  <= 4'b0000;
            acc_count <= 3'd0;
            acc_dup   <= 1'b0;
        end else if (release_frame) begin
            acc_mask  <= 4'b0000;
            acc_count <= 3'd0;
            acc_dup   <= 1'b0;
        end else if (accept) begin
            acc_mask  <= mask_next;
            acc_count <= count_next;
            acc_dup   <= dup_next;
        end
    end

    // Result registers. They load only on the last beat of a frame and
    // hold stable through HOLD, whatever the input side does.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_mask  <= 4'b0000;
            out_top   <= 2'd0;
            out_count <= 3'd0;
            out_dup   <= 1'b0;
        end else if (accept && in_last) begin
            out_mask  <= mask_next;
            out_top   <= top_next;
            out_count <= count_next;
            out_dup   <= dup_next;
        end
    end

endmodule

// File: tb/tb_index_mask_builder.sv
// -----------------------------------------------------------------------------
// tb_index_mask_builder
//
// Bench for index_mask_builder. Directed frames push hand-computed results
// into a scoreboard queue. A monitor pops one entry at each output handshake
// and compares it against the DUT outputs. While out_valid is high, the
// monitor also checks that out_top is the leading one of out_mask and that
// the held outputs stay stable. in_valid and out_ready stall randomly in
// the free-running sections.
// -----------------------------------------------------------------------------
module tb_index_mask_builder;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_idx;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_mask;
    logic [1:0] out_top;
    logic [2:0] out_count;
    logic       out_dup;

    typedef struct packed {
        logic [3:0] mask;
        logic [1:0] top;
        logic [2:0] count;
        logic       dup;
    } exp_t;

    exp_t sb[$];

    int   checks   = 0;
    int   failures = 0;

    bit   rnd_stall   = 1'b0;
    bit   ready_force = 1'b1;
    bit   ready_val   = 1'b1;

    index_mask_builder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_idx    (in_idx),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mask  (out_mask),
        .out_top   (out_top),
        .out_count (out_count),
        .out_dup   (out_dup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports a FAIL line on mismatch.
    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Independent leading-one reference, scanned from bit 0 upward.
    function automatic logic [1:0] lead_one(input logic [3:0] m);
        logic [1:0] pos;
        pos = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) pos = i[1:0];
        end
        return pos;
    endfunction

    // Drives out_ready just after each rising edge. It is either forced
    // or random with roughly two-thirds acceptance.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_force) out_ready = ready_val;
            else             out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // Sends one beat. It is called just after a rising edge. It optionally
    // idles first, then holds in_valid until the beat is taken. It returns
    // just after the accepting edge with in_valid dropped.
    task automatic apply_stimulus(input logic [1:0] idx, input logic last);
        int idle;
        int waited;
        bit got;
        idle = rnd_stall ? $urandom_range(0, 2) : 0;
        repeat (idle) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_idx   = idx;
        in_last  = last;
        waited   = 0;
        got      = 1'b0;
        while (!got && waited < 50) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        if (!got) check_output("accept_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Sends a whole frame. Beat i takes its index from list[2*i +: 2].
    // The expected result is queued first.
    task automatic send_frame(input int n, input logic [31:0] list, input exp_t e);
        sb.push_back(e);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(list[2*i +: 2], (i == n - 1));
        end
    endtask

    // Monitor: samples at the falling edge, away from the active edge.
    initial begin
        bit         prev_hold;
        logic [3:0] pm;
        logic [1:0] pt;
        logic [2:0] pc;
        logic       pd;
        exp_t       e;
        prev_hold = 1'b0;
        pm = '0; pt = '0; pc = '0; pd = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_hold = 1'b0;
            end else if (out_valid) begin
                check_output("top_model", int'(out_top), int'(lead_one(out_mask)));
                if (prev_hold) begin
                    check_output("hold_mask",  int'(out_mask),  int'(pm));
                    check_output("hold_count", int'(out_count), int'(pc));
                    check_output("hold_dup",   int'(out_dup),   int'(pd));
                    check_output("hold_top",   int'(out_top),   int'(pt));
                end
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        check_output("unexpected_frame", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check_output("frame_mask",  int'(out_mask),  int'(e.mask));
                        check_output("frame_top",   int'(out_top),   int'(e.top));
                        check_output("frame_count", int'(out_count), int'(e.count));
                        check_output("frame_dup",   int'(out_dup),   int'(e.dup));
                    end
                end
                prev_hold = !out_ready;
                pm = out_mask; pt = out_top; pc = out_count; pd = out_dup;
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    // Guards against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] list;
        int          waited;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_idx   = 2'd0;
        in_last  = 1'b0;

        // Values while reset is held. A beat offered during reset is ignored.
        #3;
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_idx   = 2'd3;
        @(negedge clk);
        @(negedge clk);
        check_output("rst_out_valid", int'(out_valid), 0);
        check_output("rst_in_ready",  int'(in_ready),  1);
        check_output("rst_out_mask",  int'(out_mask),  0);
        check_output("rst_out_top",   int'(out_top),   0);
        check_output("rst_out_count", int'(out_count), 0);
        check_output("rst_out_dup",   int'(out_dup),   0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        reset    = 1'b0;
        @(posedge clk);
        #1;

        // Beats 1, 3(last) with out_ready high: one-cycle result, then free.
        rnd_stall = 1'b0;
        ready_force = 1'b1; ready_val = 1'b1; out_ready = 1'b1;
        send_frame(2, 32'b11_01, '{mask: 4'b1010, top: 2'd3, count: 3'd2, dup: 1'b0});
        @(negedge clk);
        check_output("lat_out_valid", int'(out_valid), 1);
        check_output("lat_in_ready",  int'(in_ready),  0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_output("rel_out_valid", int'(out_valid), 0);
        check_output("rel_in_ready",  int'(in_ready),  1);
        @(posedge clk);
        #1;

        // Single beat 0(last), held for five cycles with out_ready low.
        ready_val = 1'b0; out_ready = 1'b0;
        send_frame(1, 32'b00, '{mask: 4'b0001, top: 2'd0, count: 3'd1, dup: 1'b0});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("stall_out_valid", int'(out_valid), 1);
            check_output("stall_in_ready",  int'(in_ready),  0);
            check_output("stall_out_mask",  int'(out_mask),  1);
        end
        @(posedge clk);
        #1;
        ready_val = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_output("stall_released", int'(out_valid), 0);

        // Random stalls on both sides from here on.
        @(posedge clk);
        #1;
        rnd_stall   = 1'b1;
        ready_force = 1'b0;

        // Beats 2, 2, 0(last): repeated index sets dup.
        send_frame(3, 32'b00_10_10, '{mask: 4'b0101, top: 2'd2, count: 3'd3, dup: 1'b1});

        // Nine beats cycling 0..3: count saturates at 7.
        list = '0;
        for (int i = 0; i < 9; i++) list[2*i +: 2] = i[1:0];
        send_frame(9, list, '{mask: 4'b1111, top: 2'd3, count: 3'd7, dup: 1'b1});

        // Back-to-back frames: next beat is already waiting during HOLD.
        send_frame(1, 32'b11,    '{mask: 4'b1000, top: 2'd3, count: 3'd1, dup: 1'b0});
        send_frame(2, 32'b01_10, '{mask: 4'b0110, top: 2'd2, count: 3'd2, dup: 1'b0});
        send_frame(2, 32'b11_11, '{mask: 4'b1000, top: 2'd3, count: 3'd2, dup: 1'b1});

        // Reset between beat 2 and beat 3 discards the partial frame and
        // clears the previous result asynchronously.
        rnd_stall = 1'b0;
        apply_stimulus(2'd1, 1'b0);
        apply_stimulus(2'd2, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_output("arst_out_valid", int'(out_valid), 0);
        check_output("arst_in_ready",  int'(in_ready),  1);
        check_output("arst_out_mask",  int'(out_mask),  0);
        check_output("arst_out_top",   int'(out_top),   0);
        check_output("arst_out_count", int'(out_count), 0);
        check_output("arst_out_dup",   int'(out_dup),   0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        rnd_stall = 1'b1;
        send_frame(1, 32'b01,       '{mask: 4'b0010, top: 2'd1, count: 3'd1, dup: 1'b0});
        send_frame(3, 32'b00_01_00, '{mask: 4'b0011, top: 2'd1, count: 3'd3, dup: 1'b1});

        // Drain outstanding results.
        waited = 0;
        while (sb.size() != 0 && waited < 200) begin
            @(posedge clk);
            waited++;
        end
        check_output("drain_remaining", sb.size(), 0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
